cmd_parser: RTL

CMD_PARSER -- requirements
Module: cmd_parser

---
 rtl/cmd_parser_if.sv | 24 ++
 rtl/cmd_parser.sv | 118 +++++++++++
 2 files changed

// File: rtl/cmd_parser_if.sv
// Byte-stream side (USART rx/tx) and decoded-command side of the command parser.
// The master modport is the environment; the slave modport is the parser itself.
interface cmd_parser_if;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        rx_error;
    logic [7:0]  tx_data;
    logic        tx_write;
    logic        tx_fetch;
    logic        cmd_valid;
    logic [7:0]  cmd_code;
    logic [15:0] cmd_arg;
    logic [7:0]  err_cnt;

    modport master (
        output rx_data, rx_ready, rx_error, tx_fetch,
        input  tx_data, tx_write, cmd_valid, cmd_code, cmd_arg, err_cnt
    );

    modport slave (
        input  rx_data, rx_ready, rx_error, tx_fetch,
        output tx_data, tx_write, cmd_valid, cmd_code, cmd_arg, err_cnt
    );
endinterface

// File: rtl/cmd_parser.sv
// Parses SYNC,CMD,ARG_H,ARG_L,CSUM frames from a USART byte stream, publishes good
// commands and answers every complete frame with ACK or NAK.
module cmd_parser #(
    parameter logic [7:0]  SYNC    = 8'hA5,
    parameter logic [15:0] TIMEOUT = 16'd50000,
    parameter logic [7:0]  ACK     = 8'h06,
    parameter logic [7:0]  NAK     = 8'h15
) (
    input logic         clk,
    input logic         nreset,
    cmd_parser_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, GET_CMD, GET_ARGH, GET_ARGL, GET_CSUM, RESP
    } state_t;

    state_t      state;
    logic [7:0]  cmd_byte;
    logic [7:0]  argh_byte;
    logic [7:0]  argl_byte;
    logic [15:0] tmo_cnt;
    logic [7:0]  tx_data_r;
    logic        tx_write_r;
    logic        cmd_valid_r;
    logic [7:0]  cmd_code_r;
    logic [15:0] cmd_arg_r;
    logic [7:0]  err_cnt_r;
    logic [7:0]  err_next;

    assign err_next = (err_cnt_r == 8'hFF) ? 8'hFF : err_cnt_r + 8'd1;

    assign bus.tx_data   = tx_data_r;
    assign bus.tx_write  = tx_write_r;
    assign bus.cmd_valid = cmd_valid_r;
    assign bus.cmd_code  = cmd_code_r;
    assign bus.cmd_arg   = cmd_arg_r;
    assign bus.err_cnt   = err_cnt_r;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state       <= IDLE;
            cmd_byte    <= 8'h00;
            argh_byte   <= 8'h00;
            argl_byte   <= 8'h00;
            tmo_cnt     <= 16'h0000;
            tx_data_r   <= 8'h00;
            tx_write_r  <= 1'b0;
            cmd_valid_r <= 1'b0;
            cmd_code_r  <= 8'h00;
            cmd_arg_r   <= 16'h0000;
            err_cnt_r   <= 8'h00;
        end else begin
            cmd_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    tmo_cnt <= 16'h0000;
                    // A byte flagged with a framing error is never a valid SYNC.
                    if (bus.rx_ready && !bus.rx_error && bus.rx_data == SYNC)
                        state <= GET_CMD;
                end
                GET_CMD, GET_ARGH, GET_ARGL, GET_CSUM: begin
                    if (bus.rx_error) begin
                        state     <= IDLE;
                        tmo_cnt   <= 16'h0000;
                        err_cnt_r <= err_next;
                    end else if (bus.rx_ready) begin
                        tmo_cnt <= 16'h0000;
                        case (state)
                            GET_CMD: begin
                                cmd_byte <= bus.rx_data;
                                state    <= GET_ARGH;
                            end
                            GET_ARGH: begin
                                argh_byte <= bus.rx_data;
                                state     <= GET_ARGL;
                            end
                            GET_ARGL: begin
                                argl_byte <= bus.rx_data;
                                state     <= GET_CSUM;
                            end
                            GET_CSUM: begin
                                tx_write_r <= 1'b1;
                                state      <= RESP;
                                if (bus.rx_data == (cmd_byte ^ argh_byte ^ argl_byte)) begin
                                    cmd_code_r  <= cmd_byte;
                                    cmd_arg_r   <= {argh_byte, argl_byte};
                                    cmd_valid_r <= 1'b1;
                                    tx_data_r   <= ACK;
                                end else begin
                                    tx_data_r <= NAK;
                                    err_cnt_r <= err_next;
                                end
                            end
                            default: ;
                        endcase
                    end else if (tmo_cnt == TIMEOUT - 16'd1) begin
                        state     <= IDLE;
                        tmo_cnt   <= 16'h0000;
                        err_cnt_r <= err_next;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                RESP: begin
                    // Incoming bytes and rx_error are deliberately dropped while answering.
                    tmo_cnt <= 16'h0000;
                    if (bus.tx_fetch) begin
                        tx_write_r <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
